// File: rtl/coeff_context_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : coeff_context_sequencer
// Purpose  : Walks one 4x4 coefficient group in reverse scan order, drives a
//            start/done transaction to context_bit_lookup per coefficient,
//            tracks c1Idx/c2Idx and accumulates the returned context bits
//            into a saturating group rate, handed off over valid/ready.
// Ports    : clk, rst_n (synchronous, active low)
//            cg_valid/cg_ready, cg_levels, cg_g1_cost, cg_abs_cost : group in
//            lk_start, lk_level_case, lk_c1Idx, lk_c2Idx,
//            lk_greater_one_cost, lk_level_abs_cost               : lookup req
//            lk_context_bits, lk_done                             : lookup rsp
//            res_valid/res_ready, res_bits, res_nz_count          : result out
// Options  : define SKIP_TRAILING_ZERO_EN to start each group at the highest
//            nonzero coefficient and to bypass lookups for all-zero groups.
// Revision : 1.0 - initial release
// ============================================================================
module coeff_context_sequencer #(
    parameter int LEVEL_W  = 16,
    parameter int NUM_COEF = 16,
    parameter int ACC_W    = 32,
    parameter int C1_MAX   = 8,
    parameter int C2_MAX   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cg_valid,
    output logic                          cg_ready,
    input  logic [NUM_COEF*LEVEL_W-1:0]   cg_levels,
    input  logic [15:0]                   cg_g1_cost,
    input  logic [15:0]                   cg_abs_cost,
    output logic                          lk_start,
    output logic [1:0]                    lk_level_case,
    output logic [7:0]                    lk_c1Idx,
    output logic [7:0]                    lk_c2Idx,
    output logic [15:0]                   lk_greater_one_cost,
    output logic [15:0]                   lk_level_abs_cost,
    input  logic [31:0]                   lk_context_bits,
    input  logic                          lk_done,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_W-1:0]              res_bits,
    output logic [$clog2(NUM_COEF):0]     res_nz_count
);

    localparam int c_idx_w = $clog2(NUM_COEF);
    localparam int c_nz_w  = c_idx_w + 1;
    // One extra bit over the wider operand so the carry reveals overflow.
    localparam int c_sum_w = ((ACC_W > 32) ? ACC_W : 32) + 1;

    localparam logic [c_sum_w-1:0] c_acc_max =
        {{(c_sum_w-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    localparam logic [7:0] c_c1_max = 8'(C1_MAX);
    localparam logic [7:0] c_c2_max = 8'(C2_MAX);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_issue  = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_result = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [LEVEL_W-1:0]  r_lvl [NUM_COEF];
    logic [c_idx_w-1:0]  r_idx;
    logic [7:0]          r_c1;
    logic [7:0]          r_c2;
    logic [ACC_W-1:0]    r_acc;
    logic [c_nz_w-1:0]   r_nz;

    // ------------------------------------------------------------------
    // Level unpacking of the incoming group
    // ------------------------------------------------------------------
    logic [LEVEL_W-1:0]  w_lvl_in [NUM_COEF];

    generate
        for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_unpack
            assign w_lvl_in[gi] = cg_levels[gi*LEVEL_W +: LEVEL_W];
        end
    endgenerate

    // ZERO / ONE / TWO / BASEPLUS
    function automatic logic [1:0] classify(input logic [LEVEL_W-1:0] lvl);
        if (lvl == '0)
            return 2'd0;
        else if (lvl == LEVEL_W'(1))
            return 2'd1;
        else if (lvl == LEVEL_W'(2))
            return 2'd2;
        else
            return 2'd3;
    endfunction

    // ------------------------------------------------------------------
    // Starting coefficient for a newly accepted group
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0]  w_top_idx;
    logic                w_any_nz;

`ifdef SKIP_TRAILING_ZERO_EN
    // Ascending scan: the last nonzero hit is the highest index, which is
    // the first coefficient in reverse scan order worth sending.
    always_comb begin
        w_top_idx = '0;
        w_any_nz  = 1'b0;
        for (int i = 0; i < NUM_COEF; i++) begin
            if (w_lvl_in[i] != '0) begin
                w_top_idx = c_idx_w'(i);
                w_any_nz  = 1'b1;
            end
        end
    end
`else
    // Every coefficient is issued, zeros included.
    assign w_top_idx = {c_idx_w{1'b1}};
    assign w_any_nz  = 1'b1;
`endif

    logic [1:0] w_first_case;
    assign w_first_case = classify(w_lvl_in[w_top_idx]);

    // ------------------------------------------------------------------
    // Per-coefficient update applied when the lookup completes
    // ------------------------------------------------------------------
    logic [LEVEL_W-1:0]  w_cur_level;
    logic                w_cur_nz;
    logic                w_cur_ge2;
    logic [7:0]          w_c1_upd;
    logic [7:0]          w_c2_upd;
    logic [c_nz_w-1:0]   w_nz_upd;
    logic [c_idx_w-1:0]  w_nxt_idx;
    logic [1:0]          w_nxt_case;
    logic [c_sum_w-1:0]  w_sum;
    logic [ACC_W-1:0]    w_acc_upd;

    assign w_cur_level = r_lvl[r_idx];
    assign w_cur_nz    = (w_cur_level != '0);
    assign w_cur_ge2   = (w_cur_level >= LEVEL_W'(2));

    always_comb begin
        w_c1_upd = r_c1;
        if (w_cur_nz)
            w_c1_upd = (r_c1 >= c_c1_max) ? c_c1_max : (r_c1 + 8'd1);
    end

    // c2 advances on levels >= 2 only while c1 (before this coefficient)
    // is still below its ceiling.
    always_comb begin
        w_c2_upd = r_c2;
        if (w_cur_ge2 && (r_c1 < c_c1_max))
            w_c2_upd = (r_c2 >= c_c2_max) ? c_c2_max : (r_c2 + 8'd1);
    end

    assign w_nz_upd   = r_nz + c_nz_w'(w_cur_nz);
    assign w_nxt_idx  = r_idx - c_idx_w'(1);
    assign w_nxt_case = classify(r_lvl[w_nxt_idx]);

    assign w_sum     = c_sum_w'(r_acc) + c_sum_w'(lk_context_bits);
    assign w_acc_upd = (w_sum > c_acc_max) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state             <= c_st_idle;
            for (int i = 0; i < NUM_COEF; i++)
                r_lvl[i] <= '0;
            r_idx               <= '0;
            r_c1                <= '0;
            r_c2                <= '0;
            r_acc               <= '0;
            r_nz                <= '0;
            cg_ready            <= 1'b1;
            lk_start            <= 1'b0;
            lk_level_case       <= 2'd0;
            lk_c1Idx            <= 8'd0;
            lk_c2Idx            <= 8'd0;
            lk_greater_one_cost <= 16'd0;
            lk_level_abs_cost   <= 16'd0;
            res_valid           <= 1'b0;
            res_bits            <= '0;
            res_nz_count        <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cg_valid) begin
                        // Snapshot the whole group; cg_* may change freely
                        // from here on.
                        r_lvl               <= w_lvl_in;
                        lk_greater_one_cost <= cg_g1_cost;
                        lk_level_abs_cost   <= cg_abs_cost;
                        r_idx               <= w_top_idx;
                        r_c1                <= 8'd0;
                        r_c2                <= 8'd0;
                        r_acc               <= '0;
                        r_nz                <= '0;
                        cg_ready            <= 1'b0;
                        lk_c1Idx            <= 8'd0;
                        lk_c2Idx            <= 8'd0;
                        if (w_any_nz) begin
                            lk_start      <= 1'b1;
                            lk_level_case <= w_first_case;
                            r_state       <= c_st_issue;
                        end else begin
                            res_valid    <= 1'b1;
                            res_bits     <= '0;
                            res_nz_count <= '0;
                            r_state      <= c_st_result;
                        end
                    end
                end

                c_st_issue: begin
                    // Request data stays put until the matching lk_done.
                    lk_start <= 1'b0;
                    r_state  <= c_st_wait;
                end

                c_st_wait: begin
                    if (lk_done) begin
                        r_acc <= w_acc_upd;
                        r_c1  <= w_c1_upd;
                        r_c2  <= w_c2_upd;
                        r_nz  <= w_nz_upd;
                        if (r_idx == '0) begin
                            res_valid    <= 1'b1;
                            res_bits     <= w_acc_upd;
                            res_nz_count <= w_nz_upd;
                            r_state      <= c_st_result;
                        end else begin
                            // Next request carries the counters as they
                            // stand before that coefficient is counted.
                            r_idx         <= w_nxt_idx;
                            lk_start      <= 1'b1;
                            lk_level_case <= w_nxt_case;
                            lk_c1Idx      <= w_c1_upd;
                            lk_c2Idx      <= w_c2_upd;
                            r_state       <= c_st_issue;
                        end
                    end
                end

                c_st_result: begin
                    // cg_ready was dropped at acceptance and only returns
                    // here, so the next group lands one cycle after release.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cg_ready  <= 1'b1;
                        r_state   <= c_st_idle;
                    end
                end

                default: begin
                    lk_start  <= 1'b0;
                    res_valid <= 1'b0;
                    cg_ready  <= 1'b1;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coeff_context_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_coeff_context_sequencer
// Purpose  : Directed self-checking bench for coeff_context_sequencer with a
//            1-cycle context_bit_lookup stand-in. Honours
//            SKIP_TRAILING_ZERO_EN when it is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coeff_context_sequencer;

    localparam int LEVEL_W  = 16;
    localparam int NUM_COEF = 16;
    localparam int ACC_W    = 32;

`ifdef SKIP_TRAILING_ZERO_EN
    localparam int EXP_S1_STARTS = 4;
    localparam int EXP_S1_LAT    = 9;
    localparam int EXP_S3_STARTS = 0;
    localparam int EXP_S3_LAT    = 1;
`else
    localparam int EXP_S1_STARTS = 16;
    localparam int EXP_S1_LAT    = 33;
    localparam int EXP_S3_STARTS = 16;
    localparam int EXP_S3_LAT    = 33;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        cg_valid;
    logic                        cg_ready;
    logic [NUM_COEF*LEVEL_W-1:0] cg_levels;
    logic [15:0]                 cg_g1_cost;
    logic [15:0]                 cg_abs_cost;
    logic                        lk_start;
    logic [1:0]                  lk_level_case;
    logic [7:0]                  lk_c1Idx;
    logic [7:0]                  lk_c2Idx;
    logic [15:0]                 lk_greater_one_cost;
    logic [15:0]                 lk_level_abs_cost;
    logic [31:0]                 lk_context_bits;
    logic                        lk_done;
    logic                        res_valid;
    logic                        res_ready;
    logic [ACC_W-1:0]            res_bits;
    logic [$clog2(NUM_COEF):0]   res_nz_count;

    always #5 clk = ~clk;

    coeff_context_sequencer #(
        .LEVEL_W (LEVEL_W),
        .NUM_COEF(NUM_COEF),
        .ACC_W   (ACC_W),
        .C1_MAX  (8),
        .C2_MAX  (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cg_valid           (cg_valid),
        .cg_ready           (cg_ready),
        .cg_levels          (cg_levels),
        .cg_g1_cost         (cg_g1_cost),
        .cg_abs_cost        (cg_abs_cost),
        .lk_start           (lk_start),
        .lk_level_case      (lk_level_case),
        .lk_c1Idx           (lk_c1Idx),
        .lk_c2Idx           (lk_c2Idx),
        .lk_greater_one_cost(lk_greater_one_cost),
        .lk_level_abs_cost  (lk_level_abs_cost),
        .lk_context_bits    (lk_context_bits),
        .lk_done            (lk_done),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_bits           (res_bits),
        .res_nz_count       (res_nz_count)
    );

    // ------------------------------------------------------------------
    // Lookup stand-in: answers one cycle after lk_start. Cost is the
    // greater-one cost for any nonzero level while c1Idx < 8, plus the
    // level-abs cost for TWO/BASEPLUS while c2Idx is still 0.
    // ------------------------------------------------------------------
    logic        model_done = 1'b0;
    logic [31:0] model_bits = 32'd0;
    logic        boost      = 1'b0;
    logic [31:0] boost_bits = 32'd0;
    logic        force_done = 1'b0;
    logic [31:0] force_bits = 32'd0;

    function automatic logic [31:0] model_cost(input logic [1:0] lc,
                                               input logic [7:0] c1,
                                               input logic [7:0] c2,
                                               input logic [15:0] g1,
                                               input logic [15:0] ab);
        logic [31:0] v;
        v = 32'd0;
        if (lc != 2'd0 && c1 < 8'd8) begin
            v = {16'd0, g1};
            if (lc >= 2'd2 && c2 == 8'd0)
                v = v + {16'd0, ab};
        end
        return v;
    endfunction

    always @(posedge clk) begin
        model_done <= lk_start;
        model_bits <= model_cost(lk_level_case, lk_c1Idx, lk_c2Idx,
                                 lk_greater_one_cost, lk_level_abs_cost);
    end

    assign lk_done         = model_done | force_done;
    assign lk_context_bits = (model_done ? (model_bits + (boost ? boost_bits : 32'd0)) : 32'd0)
                           + (force_done ? force_bits : 32'd0);

    // ------------------------------------------------------------------
    // Monitors: cycle count, start pulses, transaction log
    // ------------------------------------------------------------------
    int          cyc        = 0;
    int          start_cnt  = 0;
    int          double_cnt = 0;
    logic        prev_start = 1'b0;
    logic [17:0] txn_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lk_start) begin
            start_cnt <= start_cnt + 1;
            txn_q.push_back({lk_level_case, lk_c1Idx, lk_c2Idx});
        end
        if (lk_start && prev_start)
            double_cnt <= double_cnt + 1;
        prev_start <= lk_start;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    int res_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_COEF*LEVEL_W-1:0] pack4(input logic [15:0] l3, input logic [15:0] l2,
                                                          input logic [15:0] l1, input logic [15:0] l0);
        logic [NUM_COEF*LEVEL_W-1:0] v;
        v = '0;
        v[3*LEVEL_W +: LEVEL_W] = l3;
        v[2*LEVEL_W +: LEVEL_W] = l2;
        v[1*LEVEL_W +: LEVEL_W] = l1;
        v[0*LEVEL_W +: LEVEL_W] = l0;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the accepting
    // edge, with cg_* scrambled to show they were latched.
    task automatic send_group(input string tag, input logic [NUM_COEF*LEVEL_W-1:0] lv,
                              input logic [15:0] g1, input logic [15:0] ab, output int acc_cyc);
        for (int i = 0; i < 100 && !cg_ready; i++)
            step();
        chk({tag, "_cg_ready"}, cg_ready, 1);
        cg_valid    = 1'b1;
        cg_levels   = lv;
        cg_g1_cost  = g1;
        cg_abs_cost = ab;
        acc_cyc     = cyc;
        step();
        cg_valid    = 1'b0;
        cg_levels   = '1;
        cg_g1_cost  = 16'hFFFF;
        cg_abs_cost = 16'hFFFF;
    endtask

    // Returns at the falling edge where res_valid is first seen.
    task automatic wait_result(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (res_valid)
                break;
        end
        res_cyc = cyc;
        chk({tag, "_res_valid"}, res_valid, 1);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [17:0] exp_txn [4];
    int acc_cyc;
    int base_starts;
    int base_q;
    int viol;
    logic [ACC_W-1:0] held_bits;

    initial begin
        rst_n       = 1'b0;
        cg_valid    = 1'b0;
        cg_levels   = '0;
        cg_g1_cost  = 16'd0;
        cg_abs_cost = 16'd0;
        res_ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_lk_start", lk_start, 0);
        chk("rst_res_bits", res_bits, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_cg_ready", cg_ready, 1);

        // Scenario 1: levels 1,2,5,1 at idx3..0
        base_starts = start_cnt;
        base_q      = txn_q.size();
        send_group("s1", pack4(16'd1, 16'd2, 16'd5, 16'd1), 16'd100, 16'd80, acc_cyc);
        wait_result("s1");
        chk("s1_bits", res_bits, 480);
        chk("s1_nz", res_nz_count, 4);
        chk("s1_latency", res_cyc - acc_cyc, EXP_S1_LAT);
        chk("s1_starts", start_cnt - base_starts, EXP_S1_STARTS);
        exp_txn[0] = {2'd1, 8'd0, 8'd0};
        exp_txn[1] = {2'd2, 8'd1, 8'd0};
        exp_txn[2] = {2'd3, 8'd2, 8'd1};
        exp_txn[3] = {2'd1, 8'd3, 8'd2};
        if (txn_q.size() >= base_q + 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("s1_txn%0d", k), txn_q[txn_q.size() - 4 + k], exp_txn[k]);
        end
        release_result();
        chk("s1_back_idle", cg_ready, 1);

        // Scenario 2: all levels 3, counters saturate
        base_starts = start_cnt;
        base_q      = txn_q.size();
        send_group("s2", {NUM_COEF{16'd3}}, 16'd10, 16'd5, acc_cyc);
        wait_result("s2");
        chk("s2_bits", res_bits, 85);
        chk("s2_nz", res_nz_count, 16);
        chk("s2_latency", res_cyc - acc_cyc, 33);
        chk("s2_starts", start_cnt - base_starts, 16);
        if (txn_q.size() >= base_q + 16) begin
            chk("s2_txn1", txn_q[base_q + 1], {2'd3, 8'd1, 8'd1});
            chk("s2_txn8", txn_q[base_q + 8], {2'd3, 8'd8, 8'd2});
            chk("s2_txn15", txn_q[base_q + 15], {2'd3, 8'd8, 8'd2});
        end
        release_result();

        // Accumulator saturation at all-ones
        boost      = 1'b1;
        boost_bits = 32'h4000_0000;
        send_group("sat", {NUM_COEF{16'd3}}, 16'd10, 16'd5, acc_cyc);
        wait_result("sat");
        chk("sat_bits", res_bits, 32'hFFFF_FFFF);
        chk("sat_nz", res_nz_count, 16);
        release_result();
        boost = 1'b0;

        // Scenario 3: all-zero group
        base_starts = start_cnt;
        send_group("s3", '0, 16'd50, 16'd60, acc_cyc);
        wait_result("s3");
        chk("s3_bits", res_bits, 0);
        chk("s3_nz", res_nz_count, 0);
        chk("s3_latency", res_cyc - acc_cyc, EXP_S3_LAT);
        chk("s3_starts", start_cnt - base_starts, EXP_S3_STARTS);
        release_result();

        // Scenario 4: result back-pressure with a group waiting
        send_group("s4a", pack4(16'd1, 16'd2, 16'd5, 16'd1), 16'd100, 16'd80, acc_cyc);
        wait_result("s4a");
        held_bits   = res_bits;
        chk("s4a_bits", held_bits, 480);
        cg_valid    = 1'b1;
        cg_levels   = pack4(16'd0, 16'd0, 16'd0, 16'd1);
        cg_g1_cost  = 16'd7;
        cg_abs_cost = 16'd3;
        base_starts = start_cnt;
        viol        = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_bits !== held_bits || cg_ready !== 1'b0)
                viol++;
        end
        chk("s4_hold_violations", viol, 0);
        chk("s4_no_accept_starts", start_cnt - base_starts, 0);
        release_result();
        chk("s4_idle_ready", cg_ready, 1);
        acc_cyc = cyc;
        step();
        cg_valid  = 1'b0;
        cg_levels = '1;
        chk("s4b_issue_start", lk_start, 1);
        wait_result("s4b");
        chk("s4b_bits", res_bits, 7);
        chk("s4b_nz", res_nz_count, 1);
        release_result();

        // Scenario 5: reset during WAIT with a coincident lk_done
        send_group("s5", pack4(16'd1, 16'd2, 16'd5, 16'd1), 16'd100, 16'd80, acc_cyc);
        step();
        chk("s5_in_wait_done", lk_done, 1);
        force_done = 1'b1;
        force_bits = 32'd1000;
        rst_n      = 1'b0;
        step();
        force_done = 1'b0;
        chk("s5_lk_start", lk_start, 0);
        chk("s5_res_valid", res_valid, 0);
        chk("s5_res_bits", res_bits, 0);
        chk("s5_res_nz", res_nz_count, 0);
        chk("s5_lk_case", lk_level_case, 0);
        chk("s5_lk_c1c2", {lk_c1Idx, lk_c2Idx}, 0);
        chk("s5_lk_costs", {lk_greater_one_cost, lk_level_abs_cost}, 0);
        rst_n = 1'b1;
        step();
        chk("s5_cg_ready", cg_ready, 1);
        chk("s5_post_res_valid", res_valid, 0);

        // Scenario 6: spurious lk_done in IDLE and ISSUE
        force_done = 1'b1;
        force_bits = 32'd1000;
        step();
        force_done = 1'b0;
        send_group("s6", pack4(16'd1, 16'd2, 16'd5, 16'd1), 16'd100, 16'd80, acc_cyc);
        chk("s6_in_issue", lk_start, 1);
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        wait_result("s6");
        chk("s6_bits", res_bits, 480);
        chk("s6_nz", res_nz_count, 4);
        release_result();

        chk("start_single_cycle", double_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coeff_context_sequencer.md
Name: coeff_context_sequencer

Overview:
Per-coefficient-group driver for context_bit_lookup in the CABAC rate estimator. Accepts one 4x4 coefficient group (16 absolute levels) and walks it in reverse scan order. For each coefficient it classifies the level, tracks c1Idx/c2Idx, issues a start/done transaction to the lookup, and accumulates the returned context_bits into one group rate. The result is returned to the RDOQ cost stage over a valid/ready handshake.

Parameters:
LEVEL_W, 16, width of each absolute coefficient level
NUM_COEF, 16, coefficients per group (power of two)
ACC_W, 32, width of the accumulated rate
C1_MAX, 8, c1Idx saturation value
C2_MAX, 2, c2Idx saturation value

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cg_valid  in  1  group present
cg_ready  out  1  sequencer can accept a group
cg_levels  in  NUM_COEF*LEVEL_W  abs levels; coefficient i at bits [i*LEVEL_W +: LEVEL_W]
cg_g1_cost  in  16  greater-one cost for this group
cg_abs_cost  in  16  level-abs cost for this group
lk_start  out  1  lookup start pulse
lk_level_case  out  2  0 ZERO, 1 ONE, 2 TWO, 3 BASEPLUS
lk_c1Idx  out  8  c1Idx for the current coefficient
lk_c2Idx  out  8  c2Idx for the current coefficient
lk_greater_one_cost  out  16  latched cg_g1_cost
lk_level_abs_cost  out  16  latched cg_abs_cost
lk_context_bits  in  32  lookup result
lk_done  in  1  lookup result valid
res_valid  out  1  group rate valid
res_ready  in  1  consumer accepts the rate
res_bits  out  ACC_W  accumulated group rate
res_nz_count  out  $clog2(NUM_COEF)+1  number of nonzero coefficients

Behaviour:
- Reset (rst_n=0 sampled at posedge) forces the following; applies mid-operation too:
  - state IDLE
  - all outputs 0 except cg_ready, which is 1 in the first cycle after reset
  - counters and accumulator cleared
- FSM states: IDLE, ISSUE, WAIT, RESULT.
- IDLE:
  - cg_ready=1.
  - On cg_valid: latch levels and both costs; idx=NUM_COEF-1; c1=c2=0; acc=0; nz=0; go to ISSUE.
- ISSUE:
  - lk_start=1 for exactly one cycle, with level_case/c1Idx/c2Idx for coefficient idx; go to WAIT.
  - lk_* data outputs are held stable from ISSUE until lk_done.
- WAIT:
  - lk_start=0. Waits indefinitely for lk_done.
  - On lk_done: acc += lk_context_bits, saturating at all-ones of ACC_W.
  - Counter update for coefficient idx:
    - if level != 0: nz++, and c1 = min(c1+1, C1_MAX)
    - if level >= 2 and pre-update c1 < C1_MAX: c2 = min(c2+1, C2_MAX)
  - If idx == 0, go to RESULT; else idx--, go to ISSUE.
- Classification: level 0 → 0; level 1 → 1; level 2 → 2; level ≥ 3 → 3.
- lk_c1Idx/lk_c2Idx carry the pre-update counter values, zero-extended to 8 bits.
- RESULT:
  - res_valid=1; res_bits=acc; res_nz_count=nz.
  - Outputs are held stable until res_ready; on res_valid && res_ready, go to IDLE.
  - cg_ready=0 in RESULT, so no group is accepted in the same cycle as the result is released.
- lk_done is ignored outside WAIT; no accumulation occurs.
- Latency with a 1-cycle lookup: 2 cycles per issued coefficient. With acceptance at cycle T, res_valid rises at T+1+2*NUM_COEF.
- Costs are latched at acceptance. Changes on cg_* after acceptance have no effect.

Optional Feature:
Macro SKIP_TRAILING_ZERO_EN.
- Defined:
  - At acceptance, idx starts at the highest nonzero coefficient index, found by a combinational priority search. Zeros above it are never issued.
  - An all-zero group goes IDLE → RESULT directly, with res_bits=0 and res_nz_count=0; res_valid is asserted the cycle after acceptance.
- Not defined: all NUM_COEF coefficients are issued, and ZERO cases still perform a lookup transaction.

Test Plan:
(Bench uses the real context_bit_lookup or an equivalent 1-cycle model.)
1. Levels idx3..0 = 1,2,5,1, others 0; g1=100, abs=80 → per-lookup values:
   - (ONE,c1=0,c2=0)=100
   - (TWO,1,0)=180
   - (BASEPLUS,2,1)=100
   - (ONE,3,2)=100
   - Result: res_bits=480, res_nz_count=4. Without the feature, 16 lk_start pulses; with it, 4.
2. All 16 levels = 3, g1=10, abs=5 → c1 saturates at 8 after 8 coefficients and c2 saturates at 2; res_bits=85, res_nz_count=16.
3. All levels 0 → res_bits=0. Without the feature, res_valid at T+33; with it, at T+1 and zero lk_start pulses.
4. Hold res_ready=0 for 5 cycles in RESULT with cg_valid=1 → res_bits stable, cg_ready=0, no new group accepted; release res_ready → IDLE, then accept the next group.
5. Assert rst_n=0 during WAIT, with lk_done arriving in the same cycle → next cycle:
   - all outputs 0
   - state IDLE
   - cg_ready=1 after reset deasserts
   - no accumulation from the late lk_done
6. Pulse lk_done during ISSUE and IDLE (spurious) → acc unchanged; final res_bits matches scenario 1 (480).
